// File: rtl/tdc_tap_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_tap_pattern_gen
//  Description : Self-test encoder for the TDC fine-decode path. Turns a bin
//                value into the thermometer tap snapshot that decodes to that
//                bin, pulses the decoder's go, checks the decoder's answer and
//                accumulates mismatches/timeouts. Single-bin or full sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_tap_pattern_gen #(
   parameter int NUM_TAPS   = 36,
   parameter int NUM_DECODE = 8,
   parameter bit FALLING    = 1'b0,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sweep,
   input  logic [NUM_DECODE-1:0] bin_in,
   input  logic                  dec_finished,
   input  logic [NUM_DECODE-1:0] dec_bin,
   output logic [NUM_TAPS-1:0]   taps_out,
   output logic                  dec_go,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           err_count,
   output logic                  timeout_flag,
   output logic [NUM_DECODE-1:0] last_bin
);

   // Highest bin that has a real edge inside the tap line.
   localparam logic [NUM_DECODE-1:0] c_MAX_BIN  = NUM_DECODE'(NUM_TAPS - 4);
   localparam int                    c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0]    c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GO    = 3'd2,
      S_WAIT  = 3'd3,
      S_CHECK = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_sweep;
   logic [NUM_DECODE-1:0] r_bin;
   logic [NUM_DECODE-1:0] r_cap_bin;
   logic                  r_timed_out;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [NUM_TAPS-1:0]   r_taps;
   logic                  r_dec_go;
   logic                  r_done;
   logic [15:0]           r_err;
   logic                  r_tflag;
   logic [NUM_DECODE-1:0] r_last;

   logic                  w_bin_valid;
   logic [NUM_DECODE-1:0] w_exp_bin;
   logic [NUM_TAPS-1:0]   w_taps_enc;
   logic                  w_wait_last;

   // Saturating error increment so a long soak never wraps back to zero.
   function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Out-of-range bins produce the no-edge word and are expected to decode as 0.
   assign w_bin_valid = (r_bin != '0) && (r_bin <= c_MAX_BIN);
   assign w_exp_bin   = w_bin_valid ? r_bin : '0;
   assign w_wait_last = (r_cnt == c_CNT_LAST);

   // Thermometer encode of the current bin; FALLING inverts the polarity.
   always_comb begin
      w_taps_enc = {NUM_TAPS{FALLING}};
      if (w_bin_valid) begin
         for (int j = 0; j < NUM_TAPS; j++) begin
            if (j < int'(r_bin)) begin
               w_taps_enc[j] = ~FALLING;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; a finished pulse on the last WAIT cycle wins over timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_GO;
         S_GO:    w_state_nxt = S_WAIT;
         S_WAIT:  if (dec_finished || w_wait_last) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = (r_sweep && (r_bin < c_MAX_BIN)) ? S_LOAD : S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: run setup, tap load, timeout counting, result check and pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sweep     <= 1'b0;
         r_bin       <= '0;
         r_cap_bin   <= '0;
         r_timed_out <= 1'b0;
         r_cnt       <= '0;
         r_taps      <= '0;
         r_dec_go    <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= '0;
         r_tflag     <= 1'b0;
         r_last      <= '0;
      end else begin
         // go is high exactly while in GO; done follows the FIN cycle.
         r_dec_go <= (w_state_nxt == S_GO);
         r_done   <= (r_state == S_FIN);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sweep <= sweep;
                  r_bin   <= sweep ? '0 : bin_in;
                  r_err   <= '0;
                  r_tflag <= 1'b0;
               end
            end
            S_LOAD: begin
               r_taps <= w_taps_enc;
            end
            S_GO: begin
               r_cnt       <= '0;
               r_timed_out <= 1'b0;
            end
            S_WAIT: begin
               if (dec_finished) begin
                  r_cap_bin <= dec_bin;
               end else if (w_wait_last) begin
                  r_timed_out <= 1'b1;
                  r_tflag     <= 1'b1;
                  r_err       <= f_sat_inc(r_err);
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            S_CHECK: begin
               // A timed-out step was already counted; do not also count a mismatch.
               if (!r_timed_out && (r_cap_bin != w_exp_bin)) begin
                  r_err <= f_sat_inc(r_err);
               end
               r_last <= r_bin;
               if (r_sweep && (r_bin < c_MAX_BIN)) begin
                  r_bin <= r_bin + NUM_DECODE'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign taps_out     = r_taps;
   assign dec_go       = r_dec_go;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign err_count    = r_err;
   assign timeout_flag = r_tflag;
   assign last_bin     = r_last;

endmodule
`default_nettype wire

// File: tb/tb_tdc_tap_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_tap_pattern_gen
//  Description : Bench for tdc_tap_pattern_gen. Two instances (rising and
//                falling polarity) share one behavioural decoder; an
//                event-timing model predicts go/done/busy/taps/results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_tap_pattern_gen;

   localparam int NT   = 36;
   localparam int TO   = 15;
   localparam int MAXB = NT - 4;
   localparam int BIG  = 1 << 30;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        sweep = 1'b0;
   logic [7:0]  bin_in = 8'd0;
   logic        dec_finished = 1'b0;
   logic [7:0]  dec_bin = 8'd0;

   logic [35:0] taps0, taps1;
   logic        go0, go1, busy0, busy1, done0, done1, tf0, tf1;
   logic [15:0] err0, err1;
   logic [7:0]  last0, last1;

   tdc_tap_pattern_gen #(.NUM_TAPS(NT), .NUM_DECODE(8), .FALLING(1'b0), .TIMEOUT(TO)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep), .bin_in(bin_in),
      .dec_finished(dec_finished), .dec_bin(dec_bin),
      .taps_out(taps0), .dec_go(go0), .busy(busy0), .done(done0),
      .err_count(err0), .timeout_flag(tf0), .last_bin(last0));

   tdc_tap_pattern_gen #(.NUM_TAPS(NT), .NUM_DECODE(8), .FALLING(1'b1), .TIMEOUT(TO)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .sweep(sweep), .bin_in(bin_in),
      .dec_finished(dec_finished), .dec_bin(dec_bin),
      .taps_out(taps1), .dec_go(go1), .busy(busy1), .done(done1),
      .err_count(err1), .timeout_flag(tf1), .last_bin(last1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference rules ----------------
   function automatic logic [35:0] enc(input int b, input bit fall);
      logic [35:0] t;
      t = fall ? {36{1'b1}} : 36'd0;
      if (b >= 1 && b <= MAXB) begin
         t = (36'd1 << b) - 36'd1;
         if (fall) t = ~t;
      end
      return t;
   endfunction

   function automatic int exp_bin(input int b);
      return (b >= 1 && b <= MAXB) ? b : 0;
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ---------------- behavioural decoder ----------------
   int lat_lo = 4, lat_hi = 4, p_hang = 0, p_wrong = 0;
   bit spur = 1'b0;
   int dcnt = -1;

   // Decodes DUT0's thermometer by counting ones after a random latency.
   always @(posedge clk) begin
      #1;
      dec_finished = 1'b0;
      dec_bin      = 8'($urandom);
      if (!rst) begin
         dcnt = -1;
      end else if (go0) begin
         if (int'($urandom_range(99)) < p_hang) dcnt = -1;
         else dcnt = int'($urandom_range(lat_hi, lat_lo));
         if (spur && $urandom_range(3) == 0) dec_finished = 1'b1;
      end else if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            dec_finished = 1'b1;
            dec_bin = 8'($countones(taps0));
            if (int'($urandom_range(99)) < p_wrong) dec_bin = dec_bin ^ 8'h01;
            dcnt = -1;
         end
      end else if (spur && !busy0 && $urandom_range(3) == 0) begin
         dec_finished = 1'b1;
      end
   end

   // ---------------- event-timing model + compare ----------------
   bit          m_active = 1'b0, m_wait = 1'b0, m_sweep = 1'b0;
   int          m_t = 0, m_go = 0, m_next_go = -1, m_end = -1, m_bin = 0, m_last = 0;
   logic [15:0] m_err = 16'd0;
   bit          m_tf = 1'b0;
   logic [35:0] m_t0 = 36'd0, m_t1 = 36'd0;

   task automatic resolve(input bit to);
      if (to) begin
         m_err = sat(m_err);
         m_tf  = 1'b1;
      end else if (int'(dec_bin) != exp_bin(m_bin)) begin
         m_err = sat(m_err);
      end
      m_last = m_bin;
      m_wait = 1'b0;
      if (m_sweep && m_bin < MAXB) begin
         m_bin++;
         m_next_go = cyc + 3;
      end else begin
         m_end     = cyc + 3;
         m_next_go = -1;
      end
   endtask

   // Checks every output of both instances each cycle against the model.
   always @(negedge clk) begin
      bit eg, ed, eb;
      if (!rst) begin
         chk("rst_taps0", 64'(taps0), 64'd0);  chk("rst_taps1", 64'(taps1), 64'd0);
         chk("rst_go",    64'({go0, go1}), 64'd0);
         chk("rst_busy",  64'({busy0, busy1}), 64'd0);
         chk("rst_done",  64'({done0, done1}), 64'd0);
         chk("rst_err",   64'({err0, err1}), 64'd0);
         chk("rst_tf",    64'({tf0, tf1}), 64'd0);
         chk("rst_last",  64'({last0, last1}), 64'd0);
         m_active = 1'b0; m_wait = 1'b0; m_next_go = -1; m_end = -1;
         m_err = 16'd0; m_tf = 1'b0; m_last = 0; m_t0 = 36'd0; m_t1 = 36'd0;
      end else begin
         if (m_active && cyc == m_next_go) begin
            m_go = cyc; m_wait = 1'b1;
            m_t0 = enc(m_bin, 1'b0);
            m_t1 = enc(m_bin, 1'b1);
         end
         eg = m_active && (cyc == m_next_go);
         ed = m_active && (cyc == m_end);
         eb = m_active && (cyc > m_t) && (cyc < m_end);
         chk("go0",   64'(go0),   64'(eg)); chk("go1",   64'(go1),   64'(eg));
         chk("done0", 64'(done0), 64'(ed)); chk("done1", 64'(done1), 64'(ed));
         chk("busy0", 64'(busy0), 64'(eb)); chk("busy1", 64'(busy1), 64'(eb));
         chk("taps0", 64'(taps0), 64'(m_t0)); chk("taps1", 64'(taps1), 64'(m_t1));
         if (!eb) begin
            chk("err0",  64'(err0),  64'(m_err)); chk("err1",  64'(err1),  64'(m_err));
            chk("tf0",   64'(tf0),   64'(m_tf));  chk("tf1",   64'(tf1),   64'(m_tf));
            chk("last0", 64'(last0), 64'(8'(m_last))); chk("last1", 64'(last1), 64'(8'(m_last)));
         end
         if (m_active && m_wait && cyc > m_go) begin
            if (dec_finished) resolve(1'b0);
            else if (cyc == m_go + TO) resolve(1'b1);
         end
         if (m_active && cyc >= m_end) m_active = 1'b0;
         if (!m_active && start) begin
            m_active = 1'b1; m_t = cyc; m_sweep = sweep;
            m_bin = sweep ? 0 : int'(bin_in);
            m_err = 16'd0; m_tf = 1'b0; m_wait = 1'b0;
            m_next_go = cyc + 2; m_end = BIG;
         end
      end
   end

   // ---------------- event monitor for directed literal checks ----------------
   int go_cnt = 0, done_cnt = 0, go_cyc = 0, done_cyc = 0, fin_cyc = 0;
   always @(negedge clk) begin
      if (go0) begin go_cnt++; go_cyc = cyc; end
      if (done0) begin done_cnt++; done_cyc = cyc; end
      if (dec_finished) fin_cyc = cyc;
   end

   // ---------------- stimulus ----------------
   int start_cyc = 0;

   task automatic pulse_start(input bit sw, input int b);
      @(posedge clk); #1;
      start = 1'b1; sweep = sw; bin_in = 8'(b); start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input bit noise);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(posedge clk); #1;
         if (noise) begin
            start  = busy0 && ($urandom_range(4) == 0);
            bin_in = 8'($urandom);
            sweep  = 1'($urandom_range(1));
         end
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 64'(seen), 64'd1);
      #1;
   endtask

   initial begin
      int g0, d0;
      bit hit;
      repeat (3) @(posedge clk);
      #1;
      chk("init_taps0", 64'(taps0), 64'd0);
      chk("init_busy",  64'(busy0), 64'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Single bin 10, fixed latency 4.
      g0 = go_cnt; d0 = done_cnt;
      pulse_start(1'b0, 10);
      wait_done(100, 1'b0);
      chk("s10_taps_rise", 64'(taps0), 64'h0_0000_03FF);
      chk("s10_taps_fall", 64'(taps1), 64'hF_FFFF_FC00);
      chk("s10_err",       64'({err0, err1}), 64'd0);
      chk("s10_last",      64'(last0), 64'd10);
      chk("s10_go_cnt",    64'(go_cnt - g0), 64'd1);
      chk("s10_done_cnt",  64'(done_cnt - d0), 64'd1);
      chk("s10_go_lat",    64'(go_cyc - start_cyc), 64'd2);
      chk("s10_done_lat",  64'(done_cyc - fin_cyc), 64'd3);

      // Out-of-range bin 40.
      pulse_start(1'b0, 40);
      wait_done(100, 1'b0);
      chk("s40_taps_rise", 64'(taps0), 64'd0);
      chk("s40_taps_fall", 64'(taps1), 64'hF_FFFF_FFFF);
      chk("s40_err",       64'(err0), 64'd0);
      chk("s40_last",      64'(last0), 64'd40);

      // Decoder never answers.
      p_hang = 100;
      g0 = go_cnt;
      pulse_start(1'b0, 9);
      wait_done(100, 1'b0);
      chk("to_err",     64'({err0, err1}), {32'd0, 16'd1, 16'd1});
      chk("to_flag",    64'({tf0, tf1}), 64'd3);
      chk("to_go_cnt",  64'(go_cnt - g0), 64'd1);
      chk("to_done_at", 64'(done_cyc - go_cyc), 64'd18);
      p_hang = 0;

      // Next start clears the run results.
      pulse_start(1'b0, 3);
      wait_done(100, 1'b0);
      chk("clr_err",  64'(err0), 64'd0);
      chk("clr_flag", 64'(tf0), 64'd0);
      chk("clr_last", 64'(last0), 64'd3);

      // Full sweep.
      g0 = go_cnt; d0 = done_cnt;
      pulse_start(1'b1, 0);
      wait_done(2000, 1'b0);
      chk("sw_go_cnt",   64'(go_cnt - g0), 64'd33);
      chk("sw_done_cnt", 64'(done_cnt - d0), 64'd1);
      chk("sw_err",      64'(err0), 64'd0);
      chk("sw_last",     64'(last0), 64'd32);
      chk("sw_taps",     64'(taps0), 64'h0_FFFF_FFFF);

      // Reset in the middle of a sweep at bin 5.
      pulse_start(1'b1, 0);
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         if (taps0 == 36'h1F) hit = 1'b1;
      end
      chk("rst_reach_bin5", 64'(hit), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_taps", 64'({taps0, taps1}), 64'd0);
      chk("abort_busy", 64'({busy0, go0, done0}), 64'd0);
      chk("abort_err",  64'(err0), 64'd0);
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
      pulse_start(1'b0, 7);
      wait_done(100, 1'b0);
      chk("post_rst_taps", 64'(taps0), 64'h7F);
      chk("post_rst_last", 64'(last0), 64'd7);
      chk("post_rst_err",  64'(err0), 64'd0);

      // Randomized runs: variable latency, hangs, wrong answers, spurious pulses.
      spur = 1'b1; lat_lo = 1; lat_hi = TO; p_hang = 10; p_wrong = 15;
      for (int r = 0; r < 40; r++) begin
         pulse_start(1'($urandom_range(7) == 0), int'($urandom_range(45)));
         wait_done(2000, 1'b1);
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
